// File: rtl/branch_redirect_ctrl_if.sv
// Decode/fetch-side bundle for the branch redirect controller.
// The controller uses the slave view; decode and fetch together form the master view.
interface branch_redirect_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
);
   logic              br_valid;
   logic              br_ready;
   logic              br_taken;
   logic [1:0]        br_kind;
   logic [DATA_W-1:0] pc_d;
   logic [DATA_W-1:0] imm;
   logic [25:0]       index;
   logic [DATA_W-1:0] reg_tgt;
   logic              ds_fetched;
   logic              redir_valid;
   logic [DATA_W-1:0] redir_pc;
   logic              redir_ready;
   logic              misalign;
   logic              flush;
   logic              stall_d;
   logic [CNT_W-1:0]  taken_cnt;

   modport master (
      output br_valid, br_taken, br_kind, pc_d, imm, index, reg_tgt,
             ds_fetched, redir_ready, flush,
      input  br_ready, redir_valid, redir_pc, misalign, stall_d, taken_cnt
   );

   modport slave (
      input  br_valid, br_taken, br_kind, pc_d, imm, index, reg_tgt,
             ds_fetched, redir_ready, flush,
      output br_ready, redir_valid, redir_pc, misalign, stall_d, taken_cnt
   );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: takes one resolved control transfer from decode,
// forms its target, waits for the delay-slot fetch, then hands the target to fetch.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no redirect pending, decode may present a branch
//   WAIT_DS | taken target latched, waiting for the delay-slot fetch
//   REDIR   | redirect presented to fetch, held until accepted
module branch_redirect_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic                  clock,
   input  logic                  resetn,
   branch_redirect_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_DS = 2'd1,
      REDIR   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] pc_plus4;
   logic [DATA_W-1:0] tgt_nxt;
   logic              mis_nxt;
   logic [DATA_W-1:0] tgt_q;
   logic              mis_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              br_ready;
   logic              take;
   logic              handshake;

   assign pc_plus4  = bus.pc_d + DATA_W'(4);
   // Reserved kind 11 is accepted but behaves like a not-taken branch.
   assign take      = bus.br_valid & br_ready & bus.br_taken & (bus.br_kind != 2'b11);
   assign handshake = (state == REDIR) & bus.redir_ready & ~bus.flush;

   // Target formation for the branch currently offered by decode.
   always_comb begin
      tgt_nxt = pc_plus4 + {bus.imm[DATA_W-3:0], 2'b00};
      mis_nxt = 1'b0;
      case (bus.br_kind)
         2'b01:   tgt_nxt = {pc_plus4[DATA_W-1:28], bus.index, 2'b00};
         2'b10: begin
            tgt_nxt = bus.reg_tgt;
            mis_nxt = (bus.reg_tgt[1:0] != 2'b00);
         end
         default: tgt_nxt = pc_plus4 + {bus.imm[DATA_W-3:0], 2'b00};
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; flush overrides everything.
   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (take) state_nxt = bus.ds_fetched ? REDIR : WAIT_DS;
            WAIT_DS: if (bus.ds_fetched) state_nxt = REDIR;
            REDIR:   if (bus.redir_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Target/misalign capture on a taken accept, and the accepted-redirect counter.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         tgt_q <= '0;
         mis_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (take) begin
            tgt_q <= tgt_nxt;
            mis_q <= mis_nxt;
         end
         if (handshake) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Outputs decoded from the current state.
   always_comb begin
      br_ready        = (state == IDLE) & ~bus.flush;
      bus.br_ready    = br_ready;
      bus.stall_d     = (state != IDLE);
      bus.redir_valid = (state == REDIR);
      bus.redir_pc    = tgt_q;
      bus.misalign    = mis_q & (state == REDIR);
      bus.taken_cnt   = cnt_q;
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus randomized branches,
// with a queue of expected redirects drained by an independent monitor.
module tb_branch_redirect_ctrl;

   logic clock  = 1'b0;
   logic resetn = 1'b0;

   always #5 clock = ~clock;

   branch_redirect_ctrl_if #(.DATA_W(32), .CNT_W(32)) bus ();

   branch_redirect_ctrl #(.DATA_W(32), .CNT_W(32)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   typedef struct packed {
      logic [31:0] pc;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference target computation straight from the architectural rules.
   function automatic exp_t model(input logic [1:0] kind, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [25:0] idx,
                                  input logic [31:0] rt);
      exp_t        r;
      logic [31:0] seq;
      seq   = pc + 32'd4;
      r.mis = 1'b0;
      case (kind)
         2'd0:    r.pc = seq + imm * 32'd4;
         2'd1:    r.pc = (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
         default: begin
            r.pc  = rt;
            r.mis = (rt % 32'd4) != 32'd0;
         end
      endcase
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic taken, input logic [1:0] kind, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [25:0] idx, input logic [31:0] rt,
                        input int ds_dly, input int rdy_dly, input exp_t e);
      logic redirects;
      redirects = taken && (kind != 2'b11);
      check("br_ready_idle", bus.br_ready, 1);
      bus.br_valid   = 1'b1;
      bus.br_taken   = taken;
      bus.br_kind    = kind;
      bus.pc_d       = pc;
      bus.imm        = imm;
      bus.index      = idx;
      bus.reg_tgt    = rt;
      bus.ds_fetched = (ds_dly == 0);
      if (redirects) exp_q.push_back(e);
      step();
      bus.br_valid   = 1'b0;
      bus.br_taken   = 1'($urandom);
      bus.br_kind    = 2'($urandom);
      bus.pc_d       = $urandom;
      bus.imm        = $urandom;
      bus.reg_tgt    = $urandom;
      bus.ds_fetched = 1'b0;
      if (!redirects) begin
         check("nt_stall", bus.stall_d, 0);
         check("nt_valid", bus.redir_valid, 0);
         return;
      end
      if (ds_dly > 0) begin
         for (int i = 0; i < ds_dly; i++) begin
            check("wait_stall", bus.stall_d, 1);
            check("wait_valid", bus.redir_valid, 0);
            check("wait_br_ready", bus.br_ready, 0);
            step();
         end
         bus.ds_fetched = 1'b1;
         step();
         bus.ds_fetched = 1'b0;
      end
      check("latency_valid", bus.redir_valid, 1);
      check("redir_stall", bus.stall_d, 1);
      for (int i = 0; i < rdy_dly; i++) step();
      bus.redir_ready = 1'b1;
      step();
      bus.redir_ready = 1'b0;
      check("post_hs_valid", bus.redir_valid, 0);
      check("post_hs_stall", bus.stall_d, 0);
   endtask

   // Idle cycles with stray ds_fetched / redir_ready activity that must be ignored.
   task automatic idle_gap(input int n);
      for (int i = 0; i < n; i++) begin
         bus.ds_fetched  = 1'($urandom);
         bus.redir_ready = 1'($urandom);
         step();
         check("idle_stall", bus.stall_d, 0);
         check("idle_valid", bus.redir_valid, 0);
      end
      bus.ds_fetched  = 1'b0;
      bus.redir_ready = 1'b0;
   endtask

   // Monitor: pops an expectation on every accepted redirect, tracks the
   // accepted count, and checks outputs stay frozen while fetch stalls.
   logic [31:0] exp_cnt;
   logic        pv, phs, pfl, pmis;
   logic [31:0] ppc;

   always @(negedge clock) begin
      exp_t e;
      if (!resetn) begin
         exp_cnt = 32'd0;
         pv      = 1'b0;
         phs     = 1'b0;
         pfl     = 1'b0;
         ppc     = 32'd0;
         pmis    = 1'b0;
      end else begin
         check("taken_cnt", bus.taken_cnt, exp_cnt);
         if (pv && !phs && !pfl) begin
            check("hold_valid", bus.redir_valid, 1);
            check("hold_pc", bus.redir_pc, ppc);
            check("hold_mis", bus.misalign, pmis);
         end
         if (bus.redir_valid && bus.redir_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_redirect: got pc 0x%0h, expected no redirect at %0t",
                        bus.redir_pc, $time);
            end else begin
               e = exp_q.pop_front();
               check("redir_pc", bus.redir_pc, e.pc);
               check("misalign", bus.misalign, e.mis);
            end
            exp_cnt = exp_cnt + 32'd1;
         end
         pv   = bus.redir_valid;
         phs  = bus.redir_valid && bus.redir_ready;
         pfl  = bus.flush;
         ppc  = bus.redir_pc;
         pmis = bus.misalign;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t        e;
      logic [1:0]  kind;
      logic        taken;
      logic [31:0] pc, imm, rt;
      logic [25:0] idx;
      logic [15:0] off;

      bus.br_valid    = 1'b0;
      bus.br_taken    = 1'b0;
      bus.br_kind     = 2'b00;
      bus.pc_d        = '0;
      bus.imm         = '0;
      bus.index       = '0;
      bus.reg_tgt     = '0;
      bus.ds_fetched  = 1'b0;
      bus.redir_ready = 1'b0;
      bus.flush       = 1'b0;

      #1;
      check("rst_valid", bus.redir_valid, 0);
      check("rst_pc", bus.redir_pc, 0);
      check("rst_mis", bus.misalign, 0);
      check("rst_cnt", bus.taken_cnt, 0);
      check("rst_br_ready", bus.br_ready, 1);
      check("rst_stall", bus.stall_d, 0);
      step();
      step();
      resetn = 1'b1;
      step();

      // BEQ taken with delay slot already fetched
      issue(1, 2'd0, 32'hBFC0_0010, 32'h0000_0003, 26'd0, 32'd0, 0, 2, '{pc: 32'hBFC0_0020, mis: 1'b0});
      idle_gap(2);
      // negative offset, delay slot late
      issue(1, 2'd0, 32'h0040_0100, 32'hFFFF_FFFE, 26'd0, 32'd0, 3, 0, '{pc: 32'h0040_00FC, mis: 1'b0});
      idle_gap(1);
      // J-index uses the region of PC+4
      issue(1, 2'd1, 32'h8FFF_FFFC, 32'd0, 26'h000_0100, 32'd0, 0, 1, '{pc: 32'h9000_0400, mis: 1'b0});
      // PC wrap
      issue(1, 2'd0, 32'hFFFF_FFFC, 32'd0, 26'd0, 32'd0, 1, 0, '{pc: 32'h0000_0000, mis: 1'b0});
      // JR misaligned, fetch stalls for 5 cycles
      issue(1, 2'd2, 32'h1234_5678, 32'd0, 26'd0, 32'h8000_1002, 1, 5, '{pc: 32'h8000_1002, mis: 1'b1});
      // reserved kind and plain not-taken produce nothing
      issue(1, 2'd3, 32'h0000_1000, 32'd4, 26'd0, 32'd0, 0, 0, '{pc: 32'd0, mis: 1'b0});
      issue(0, 2'd0, 32'h0000_1000, 32'd4, 26'd0, 32'd0, 0, 0, '{pc: 32'd0, mis: 1'b0});

      // flush in REDIR together with redir_ready and a fresh branch
      bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_kind = 2'd0;
      bus.pc_d = 32'h0000_2000; bus.imm = 32'd8; bus.ds_fetched = 1'b1;
      step();
      bus.br_valid = 1'b0; bus.ds_fetched = 1'b0;
      check("flush_pre_valid", bus.redir_valid, 1);
      bus.flush = 1'b1; bus.redir_ready = 1'b1; bus.br_valid = 1'b1; bus.ds_fetched = 1'b1;
      #1;
      check("flush_br_ready", bus.br_ready, 0);
      step();
      bus.flush = 1'b0; bus.redir_ready = 1'b0; bus.br_valid = 1'b0; bus.ds_fetched = 1'b0;
      check("flush_valid", bus.redir_valid, 0);
      check("flush_stall", bus.stall_d, 0);
      idle_gap(2);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         kind  = 2'($urandom_range(0, 3));
         taken = ($urandom_range(0, 3) != 0);
         pc    = $urandom;
         off   = 16'($urandom);
         imm   = {{16{off[15]}}, off};
         idx   = 26'($urandom);
         rt    = $urandom;
         e     = model(kind, pc, imm, idx, rt);
         issue(taken, kind, pc, imm, idx, rt, $urandom_range(0, 3), $urandom_range(0, 3), e);
         idle_gap($urandom_range(0, 2));
      end

      // reset while waiting for the delay slot
      bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_kind = 2'd0;
      bus.pc_d = 32'h0000_3000; bus.imm = 32'd1; bus.ds_fetched = 1'b0;
      step();
      bus.br_valid = 1'b0;
      check("pre_rst_stall", bus.stall_d, 1);
      resetn = 1'b0;
      #1;
      check("arst_valid", bus.redir_valid, 0);
      check("arst_stall", bus.stall_d, 0);
      check("arst_cnt", bus.taken_cnt, 0);
      step();
      resetn = 1'b1;
      step();
      issue(0, 2'd1, 32'h0000_4000, 32'd0, 26'h3, 32'd0, 0, 0, '{pc: 32'd0, mis: 1'b0});
      idle_gap(2);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_redirects: got %0d outstanding, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
